// File: rtl/operand_issue.sv
// Operand-fetch and issue stage ahead of the three-source ALU.
// Holds the architectural register file, a per-register pending scoreboard
// for RAW/WAW protection, and a valid/ready output slot feeding the ALU.
module operand_issue #(
    parameter int unsigned NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] in_rs1,
    input  logic [$clog2(NREG)-1:0] in_rs2,
    input  logic [$clog2(NREG)-1:0] in_rs3,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [31:0]             in_imm,
    input  logic [4:0]              in_alucontrol,
    input  logic [1:0]              in_mode,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [31:0]             wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             SrcA,
    output logic [31:0]             SrcB,
    output logic [31:0]             SrcC,
    output logic [4:0]              alucontrol,
    output logic [1:0]              mode,
    output logic [$clog2(NREG)-1:0] out_rd
);

    localparam int unsigned IW = $clog2(NREG);

    logic [31:0]     regs_q [NREG];
    logic [NREG-1:1] pend_q;
    logic [NREG-1:1] pend_d;
    logic [NREG-1:0] pend_eff;

    logic        use_rs2;
    logic        use_rs3;
    logic        hazard;
    logic        accept;
    logic        wb_write;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;

    // Register read with same-cycle writeback bypass; x0 always reads zero.
    function automatic logic [31:0] rf_read(
        input logic [31:0]   stored,
        input logic [IW-1:0] idx,
        input logic          bp_en,
        input logic [IW-1:0] bp_rd,
        input logic [31:0]   bp_data
    );
        if (idx == '0) begin
            return 32'h0;
        end else if (bp_en && (bp_rd == idx)) begin
            return bp_data;
        end else begin
            return stored;
        end
    endfunction

    assign wb_write = wb_en && (wb_rd != '0);

    // Hazard detection against effective pending bits and issue handshake.
    always_comb begin
        // Bit 0 stays clear so x0 never blocks; a writeback this cycle releases its register.
        pend_eff = {pend_q, 1'b0};
        if (wb_en) begin
            pend_eff[wb_rd] = 1'b0;
        end
        use_rs2  = (in_mode == 2'b00) || (in_mode == 2'b01);
        use_rs3  = (in_mode == 2'b00);
        hazard   = pend_eff[in_rs1]
                 | (use_rs2 & pend_eff[in_rs2])
                 | (use_rs3 & pend_eff[in_rs3])
                 | pend_eff[in_rd];
        in_ready = (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    // Operand selection by mode; unused operands are forced to zero.
    always_comb begin
        op_a = rf_read(regs_q[in_rs1], in_rs1, wb_en, wb_rd, wb_data);
        op_b = 32'h0;
        op_c = 32'h0;
        if (use_rs2) begin
            op_b = rf_read(regs_q[in_rs2], in_rs2, wb_en, wb_rd, wb_data);
        end
        if (use_rs3) begin
            op_c = rf_read(regs_q[in_rs3], in_rs3, wb_en, wb_rd, wb_data);
        end else if (in_mode == 2'b11) begin
            op_c = in_imm;
        end
    end

    // Scoreboard next state: writeback clears, accept sets, and set wins on collision.
    always_comb begin
        pend_d = pend_q;
        if (wb_write) begin
            pend_d[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            pend_d[in_rd] = 1'b1;
        end
    end

    // Register file and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 32'h0;
            end
            pend_q <= '0;
        end else begin
            if (wb_write) begin
                regs_q[wb_rd] <= wb_data;
            end
            pend_q <= pend_d;
        end
    end

    // Output slot: load on accept, drain on consume, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            SrcA       <= 32'h0;
            SrcB       <= 32'h0;
            SrcC       <= 32'h0;
            alucontrol <= 5'h0;
            mode       <= 2'b00;
            out_rd     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            SrcA       <= op_a;
            SrcB       <= op_b;
            SrcC       <= op_c;
            alucontrol <= in_alucontrol;
            mode       <= in_mode;
            out_rd     <= in_rd;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_operand_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rs3, in_rd;
    logic [31:0] in_imm;
    logic [4:0]  in_alucontrol;
    logic [1:0]  in_mode;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB, SrcC;
    logic [4:0]  alucontrol;
    logic [1:0]  mode;
    logic [4:0]  out_rd;

    int n_checks = 0;
    int n_fail   = 0;

    operand_issue #(.NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs3       (in_rs3),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_alucontrol(in_alucontrol),
        .in_mode      (in_mode),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .SrcC         (SrcC),
        .alucontrol   (alucontrol),
        .mode         (mode),
        .out_rd       (out_rd)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_reg [32];
    bit          m_pend [32];
    bit          m_ov;
    logic [31:0] m_a, m_b, m_c;
    logic [4:0]  m_alu, m_rd;
    logic [1:0]  m_mode;
    bit          m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_src(input logic [1:0] md);
        return (md == 2'd0) ? 3 : (md == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'h0;
        if (wb_en && int'(wb_rd) == idx) return wb_data;
        return m_reg[idx];
    endfunction

    function automatic bit m_busy(input int idx);
        return (idx != 0) && m_pend[idx] && !(wb_en && int'(wb_rd) == idx);
    endfunction

    function automatic bit m_ready();
        int  ns;
        bit  hz;
        ns = n_src(in_mode);
        hz = m_busy(int'(in_rs1)) || (ns >= 2 && m_busy(int'(in_rs2)))
          || (ns == 3 && m_busy(int'(in_rs3))) || m_busy(int'(in_rd));
        return (!m_ov || out_ready) && !hz;
    endfunction

    // Model update at each clock edge, cleared asynchronously by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_ov = 0; m_a = 0; m_b = 0; m_c = 0; m_alu = 0; m_rd = 0; m_mode = 0;
        end else begin
            m_acc = in_valid && m_ready();
            if (m_acc) begin
                m_a    = m_read(int'(in_rs1));
                m_b    = (n_src(in_mode) >= 2) ? m_read(int'(in_rs2)) : 32'h0;
                m_c    = (in_mode == 2'd0) ? m_read(int'(in_rs3)) :
                         (in_mode == 2'd3) ? in_imm : 32'h0;
                m_alu  = in_alucontrol;
                m_mode = in_mode;
                m_rd   = in_rd;
                m_ov   = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (wb_en && wb_rd != 0) begin
                m_reg[wb_rd]  = wb_data;
                m_pend[wb_rd] = 1'b0;
            end
            if (m_acc && in_rd != 0) m_pend[in_rd] = 1'b1;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ready());
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("SrcA", SrcA, m_a);
            chk("SrcB", SrcB, m_b);
            chk("SrcC", SrcC, m_c);
            chk("alucontrol", alucontrol, m_alu);
            chk("mode", mode, m_mode);
            chk("out_rd", out_rd, m_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] md, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] r3, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [4:0] alu);
        in_mode = md; in_rs1 = r1; in_rs2 = r2; in_rs3 = r3; in_rd = rd;
        in_imm = imm; in_alucontrol = alu; in_valid = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
    endtask

    initial begin
        in_valid = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
        in_rs1 = 0; in_rs2 = 0; in_rs3 = 0; in_rd = 0; in_imm = 0;
        in_alucontrol = 0; in_mode = 0;
        repeat (2) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_SrcA", SrcA, 0);
        chk("rst_SrcB", SrcB, 0);
        chk("rst_SrcC", SrcC, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_alucontrol", alucontrol, 0);
        chk("rst_mode", mode, 0);
        rst = 0;

        // Load x5..x7 and issue an R4 instruction
        wb(5, 32'hAA); step();
        wb(6, 32'h55); step();
        wb(7, 32'h1);  step();
        wb_en = 0;
        issue(2'd0, 5, 6, 7, 8, 0, 5'h3);
        #1 chk("r4_ready", in_ready, 1);
        step(); in_valid = 0;
        chk("r4_valid", out_valid, 1);
        chk("r4_SrcA", SrcA, 32'hAA);
        chk("r4_SrcB", SrcB, 32'h55);
        chk("r4_SrcC", SrcC, 32'h1);
        chk("r4_rd", out_rd, 8);
        chk("r4_alu", alucontrol, 5'h3);

        // I-type alongside retirement of x8
        wb(8, 32'h88);
        issue(2'd3, 5, 0, 0, 0, 32'hFFFF_FFFC, 5'h7);
        step(); wb_en = 0; in_valid = 0;
        chk("itype_SrcA", SrcA, 32'hAA);
        chk("itype_SrcB", SrcB, 0);
        chk("itype_SrcC", SrcC, 32'hFFFF_FFFC);
        chk("itype_mode", mode, 2'd3);

        // rs1=x0 while a writeback targets x0
        issue(2'd2, 0, 0, 0, 0, 0, 5'h1);
        wb(0, 32'hDEAD);
        #1 chk("x0_ready", in_ready, 1);
        step(); in_valid = 0; wb_en = 0;
        chk("x0_SrcA", SrcA, 0);

        // RAW on x9 released by same-cycle writeback
        issue(2'd2, 0, 0, 0, 9, 0, 5'h2);
        step();
        issue(2'd1, 5, 9, 0, 11, 0, 5'h4);
        repeat (3) begin
            #1 chk("raw_stall", in_ready, 0);
            step();
        end
        wb(9, 32'h1234);
        #1 chk("raw_release", in_ready, 1);
        step(); in_valid = 0; wb_en = 0;
        chk("raw_SrcA", SrcA, 32'hAA);
        chk("raw_SrcB", SrcB, 32'h1234);
        chk("raw_rd", out_rd, 11);
        wb(11, 32'h0); step(); wb_en = 0;

        // Unused sources do not stall
        issue(2'd2, 0, 0, 0, 9, 0, 5'h2);
        step();
        issue(2'd2, 5, 9, 9, 0, 0, 5'h5);
        #1 chk("gate_ready", in_ready, 1);
        step(); in_valid = 0;
        chk("gate_SrcA", SrcA, 32'hAA);
        chk("gate_SrcB", SrcB, 0);
        chk("gate_SrcC", SrcC, 0);
        wb(9, 32'h9); step(); wb_en = 0;

        // WAW on x10, then collision where the new set wins
        issue(2'd2, 0, 0, 0, 10, 0, 5'h2);
        step();
        repeat (2) begin
            #1 chk("waw_stall", in_ready, 0);
            step();
        end
        wb(10, 32'h10);
        #1 chk("waw_release", in_ready, 1);
        step(); wb_en = 0;
        #1 chk("waw_pend_kept", in_ready, 0);
        in_valid = 0;
        wb(10, 32'h11); step(); wb_en = 0;

        // Backpressure holds the slot
        out_ready = 0;
        issue(2'd0, 5, 6, 7, 12, 0, 5'h6);
        step();
        issue(2'd1, 6, 7, 0, 13, 0, 5'h8);
        repeat (5) begin
            #1;
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_SrcA", SrcA, 32'hAA);
            chk("bp_rd", out_rd, 12);
            step();
        end
        out_ready = 1;
        #1 chk("bp_release", in_ready, 1);
        step();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_SrcA", SrcA, 32'h55);
        chk("bp_next_SrcB", SrcB, 32'h1);
        chk("bp_next_rd", out_rd, 13);

        // Reset mid-stall clears slot and scoreboard immediately
        out_ready = 0;
        issue(2'd2, 0, 0, 0, 14, 0, 5'h9);
        step();
        issue(2'd2, 13, 0, 0, 0, 0, 5'h9);
        #1 chk("pre_rst_ready", in_ready, 0);
        #1 rst = 1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        in_valid = 0;
        step();
        rst = 0; out_ready = 1;
        issue(2'd0, 5, 6, 7, 0, 0, 5'h0);
        step(); in_valid = 0;
        chk("post_rst_SrcA", SrcA, 0);
        chk("post_rst_SrcB", SrcB, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int k;
            int pick;
            in_valid      = ($urandom_range(0, 99) < 70);
            in_mode       = 2'($urandom_range(0, 3));
            in_rs1        = 5'($urandom_range(0, 7));
            in_rs2        = 5'($urandom_range(0, 7));
            in_rs3        = 5'($urandom_range(0, 7));
            in_rd         = 5'($urandom_range(0, 7));
            in_imm        = $urandom;
            in_alucontrol = 5'($urandom_range(0, 31));
            out_ready     = ($urandom_range(0, 99) < 75);
            wb_en         = 0;
            if ($urandom_range(0, 99) < 40) begin
                k    = $urandom_range(0, 7);
                pick = k;
                for (int j = 0; j < 8; j++) begin
                    if (m_pend[(k + j) % 8]) begin
                        pick = (k + j) % 8;
                        break;
                    end
                end
                wb(5'(pick), $urandom);
            end
            step();
        end
        in_valid = 0; wb_en = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand-fetch and issue stage directly upstream of the three-source ALU. It holds the 32x32 architectural register file and reads up to three sources per instruction (rs1/rs2/rs3, or rs1 plus immediate for I-type). A per-register scoreboard blocks RAW and WAW hazards against results still in flight. Accepted instructions are registered into a valid/ready output slot that drives the ALU's SrcA/SrcB/SrcC, alucontrol and mode inputs.

## Interface
- NREG, 32, register count (index width 5); x0 hardwired to zero
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2, in_rs3  in  5 each  source register indices
- in_rd  in  5  destination index; 0 means no destination
- in_imm  in  32  immediate, already sign-extended
- in_alucontrol  in  5  ALU operation code, passed through
- in_mode  in  2  00 R4, 01 R3, 10 R2, 11 I-type
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback index
- wb_data  in  32  writeback value
- out_valid  out  1  operands valid for the ALU
- out_ready  in  1  ALU consumes the slot
- SrcA, SrcB, SrcC  out  32 each  operands
- alucontrol  out  5  registered in_alucontrol
- mode  out  2  registered in_mode
- out_rd  out  5  registered in_rd

## Operation
- Source usage by mode:
  - 00: rs1, rs2, rs3.
  - 01: rs1, rs2.
  - 10: rs1 only.
  - 11: rs1 only.
  - Unused operand outputs are driven to 0.
  - In mode 11, SrcC = in_imm.
- Register read: x0 always reads 0. If wb_en && wb_rd==rs && rs!=0, the read returns wb_data (same-cycle bypass).
- Register write: on wb_en && wb_rd!=0, reg[wb_rd] <= wb_data. Writes to x0 are ignored.
- Scoreboard `pend[31:1]`: a register counts as effectively pending when its pend bit is set and it is not being cleared by a writeback this cycle.
- hazard = any used source is effectively pending, OR (in_rd!=0 and pend[in_rd] is effectively pending).
- in_ready = (!out_valid || out_ready) && !hazard. in_ready does not depend on in_valid.
- Accept (in_valid && in_ready):
  - Output slot loads operands, alucontrol, mode and rd.
  - out_valid <= 1.
  - If in_rd!=0, pend[in_rd] <= 1.
- Writeback clears pend[wb_rd]. If the same index is set by an accept in the same cycle, the set wins.
- A writeback to a non-pending register is legal: it writes and leaves pend at 0.
- If out_valid && out_ready with no accept, out_valid <= 0.
- While out_valid && !out_ready, all output fields hold stable.
- Reset values:
  - All registers 0.
  - pend all 0.
  - out_valid 0.
  - SrcA/SrcB/SrcC/out_rd 0.
  - alucontrol 0, mode 0.
  - in_ready evaluates to 1 after reset.
- Reset mid-operation discards the slot contents and all pending state. No writeback is expected for instructions issued before reset.

## Timing
- Latency: accept at edge N gives out_valid high after edge N, with operands captured at N.
- Throughput: one instruction per cycle when out_ready is held high and there are no hazards.
- Writeback-to-dependent issue: a dependent instruction can be accepted in the same cycle its producer's wb_en is asserted, using the bypassed value. No bubble.
- in_ready is combinational from in_* fields, the pend bits, wb_* and out_ready. There is no path from out_ready to out_valid within a cycle.

## Test plan
- Reset, then write via wb: wb x5=0x0000_00AA, x6=0x0000_0055, x7=0x1. Issue mode 00 with rs1=5, rs2=6, rs3=7, rd=8. Required: SrcA=0xAA, SrcB=0x55, SrcC=0x1, out_valid one cycle after accept.
- Issue mode 11 with rs1=5, imm=0xFFFF_FFFC. Required: SrcB=0, SrcC=0xFFFF_FFFC. Also issue rs1=0 with a pending wb to x0. Required: SrcA=0 and no stall.
- RAW: issue rd=9, then the next instruction has rs2=9 (mode 01). Required: in_ready=0 until wb_en with wb_rd=9 and data 0x1234. In that cycle in_ready=1 and SrcB=0x1234 after the edge.
- Mode gating: with x9 pending, issue mode 10 with rs2=9 and rs3=9. Required: accepted, no stall.
- WAW: issue rd=10 and hold it pending. A second instruction with rd=10 stalls until wb x10. Simultaneous wb x10 with acceptance of a new rd=10 leaves pend[10]=1.
- Backpressure: hold out_ready=0 with out_valid=1. Required: in_ready=0 and outputs stable for 5 cycles. Then raise out_ready with a new in_valid. Required: back-to-back transfer with no bubble. Assert rst mid-stall. Required: out_valid=0 and pend cleared immediately (asynchronous).
